// File: rtl/vedic3_mac_acc_if.sv
// Operand/result handshake bundle for vedic3_mac_acc.
//   in_valid/in_ready/in_a/in_b/in_last : operand pair stream (source -> block)
//   out_valid/out_ready/out_sum/out_count/out_ovf : burst result (block -> consumer)
// Modports: master = operand source + result consumer side, slave = the MAC block.
interface vedic3_mac_acc_if #(
    parameter int unsigned ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_a;
    logic [2:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/vedic3_mac_acc.sv
// Sequential multiply-accumulate over bursts of 3-bit operand pairs.
// Each accepted pair is registered, multiplied by a vedic3bit instance the next
// cycle and summed; the burst total is presented on the result port until popped.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : vedic3_mac_acc_if.slave (operand stream in, burst result out)
// Parameters: ACC_W (6..32) accumulator width, BURST_LEN (1..255) beats per burst.
// Build option: define SATURATE_EN to clamp the sum at 2^ACC_W-1 on overflow
// instead of wrapping.

// 3x3 Urdhva-Tiryagbhyam multiplier: column-wise crosswise sums with ripple carries.
module vedic3bit (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [5:0] p
);
    logic [1:0] col1;
    logic [2:0] col2;
    logic [2:0] col3;
    logic [1:0] col4;

    always_comb begin
        col1 = 2'(a[1] & b[0]) + 2'(a[0] & b[1]);
        col2 = 3'(a[2] & b[0]) + 3'(a[1] & b[1]) + 3'(a[0] & b[2]) + 3'(col1[1]);
        col3 = 3'(a[2] & b[1]) + 3'(a[1] & b[2]) + 3'(col2[2:1]);
        // Product never exceeds 49, so the top column fits in two bits.
        col4 = 2'(a[2] & b[2]) + col3[2:1];
        p    = {col4, col3[0], col2[0], col1[0], a[0] & b[0]};
    end
endmodule

module vedic3_mac_acc #(
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vedic3_mac_acc_if.slave       bus
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CNTX_W = CNT_W + 1;
    localparam int unsigned SUM_W  = ACC_W + 1;

    typedef enum logic [1:0] {IDLE, ACC, FLUSH, HOLD} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_a_q, op_a_d;
    logic [2:0]       op_b_q, op_b_d;
    logic             p_vld_q, p_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_stk_q, ovf_stk_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [5:0]        prod;
    logic [SUM_W-1:0]  sum_wide;
    logic              carry;
    logic [ACC_W-1:0]  acc_nxt;
    logic              accept;
    logic [CNTX_W-1:0] cnt_inc;
    logic              last_beat;

    vedic3bit u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (prod)
    );

    // Accumulator datapath: one extra bit exposes the carry out.
    always_comb begin
        sum_wide = SUM_W'(acc_q) + SUM_W'(prod);
        carry    = p_vld_q & sum_wide[ACC_W];
`ifdef SATURATE_EN
        // Once clamped, the sum stays pinned for the rest of the burst.
        acc_nxt  = (ovf_stk_q | carry) ? '1 : sum_wide[ACC_W-1:0];
`else
        acc_nxt  = sum_wide[ACC_W-1:0];
`endif
    end

    // Input handshake and burst-close detection.
    always_comb begin
        accept    = bus.in_valid & in_ready_q;
        cnt_inc   = CNTX_W'(cnt_q) + CNTX_W'(1);
        last_beat = bus.in_last | (cnt_inc == CNTX_W'(BURST_LEN));
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        p_vld_d     = 1'b0;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_stk_d   = ovf_stk_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            op_a_d  = bus.in_a;
            op_b_d  = bus.in_b;
            p_vld_d = 1'b1;
            cnt_d   = cnt_inc[CNT_W-1:0];
        end

        if (p_vld_q) begin
            acc_d     = acc_nxt;
            ovf_stk_d = ovf_stk_q | carry;
        end

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    state_d = last_beat ? FLUSH : ACC;
                end
            end
            FLUSH: begin
                // The closing product lands in the same cycle the result is latched.
                out_sum_d   = acc_nxt;
                out_count_d = cnt_q;
                out_ovf_d   = ovf_stk_q | carry;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_stk_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == ACC);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            p_vld_q     <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_stk_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            p_vld_q     <= p_vld_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_stk_q   <= ovf_stk_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_vedic3_mac_acc.sv
// Directed bench for vedic3_mac_acc: three instances cover the default
// configuration (ACC_W=12, BURST_LEN=8), a narrow overflow case (ACC_W=6,
// BURST_LEN=2) and single-beat bursts (BURST_LEN=1) for the full product table.
module tb_vedic3_mac_acc;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    vedic3_mac_acc_if #(.ACC_W(12)) ia ();
    vedic3_mac_acc_if #(.ACC_W(6))  ib ();
    vedic3_mac_acc_if #(.ACC_W(12)) ic ();

    vedic3_mac_acc #(.ACC_W(12), .BURST_LEN(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    vedic3_mac_acc #(.ACC_W(6),  .BURST_LEN(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    vedic3_mac_acc #(.ACC_W(12), .BURST_LEN(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300us;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send_a(input logic [2:0] a, input logic [2:0] b, input logic last);
        int n = 0;
        ia.in_valid = 1'b1;
        ia.in_a     = a;
        ia.in_b     = b;
        ia.in_last  = last;
        while (!ia.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_a_ready", 32'(ia.in_ready), 1);
        @(negedge clk);
        ia.in_valid = 1'b0;
    endtask

    // Wait for a result, check it, pop it and check the return to IDLE.
    task automatic expect_a(input string tag, input int sum, input int cnt, input int ovf);
        int n = 0;
        while (!ia.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(ia.out_valid), 1);
        check({tag, "_sum"},   32'(ia.out_sum), sum);
        check({tag, "_count"}, 32'(ia.out_count), cnt);
        check({tag, "_ovf"},   32'(ia.out_ovf), ovf);
        check({tag, "_rdy_hold"}, 32'(ia.in_ready), 0);
        ia.out_ready = 1'b1;
        @(negedge clk);
        ia.out_ready = 1'b0;
        check({tag, "_pop_valid"}, 32'(ia.out_valid), 0);
        check({tag, "_pop_rdy"},   32'(ia.in_ready), 1);
    endtask

    initial begin
        int exp5;
        rst_n = 1'b0;
        ia.in_valid = 1'b0; ia.in_a = '0; ia.in_b = '0; ia.in_last = 1'b0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_a = '0; ib.in_b = '0; ib.in_last = 1'b0; ib.out_ready = 1'b0;
        ic.in_valid = 1'b0; ic.in_a = '0; ic.in_b = '0; ic.in_last = 1'b0; ic.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_in_ready",  32'(ia.in_ready), 0);
        check("rst_out_valid", 32'(ia.out_valid), 0);
        check("rst_out_sum",   32'(ia.out_sum), 0);
        check("rst_out_count", 32'(ia.out_count), 0);
        check("rst_out_ovf",   32'(ia.out_ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_ready", 32'(ia.in_ready), 1);

        // Reset mid-burst discards the partial sum
        send_a(3'd2, 3'd2, 1'b0);
        send_a(3'd1, 3'd1, 1'b0);
        send_a(3'd3, 3'd3, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ia.in_ready), 0);
        check("mid_rst_valid", 32'(ia.out_valid), 0);
        check("mid_rst_sum",   32'(ia.out_sum), 0);
        check("mid_rst_count", 32'(ia.out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_a(3'd2, 3'd3, 1'b1);
        expect_a("t1", 6, 1, 0);

        // Full burst of 8, back-to-back, closed by the beat count
        for (int i = 0; i < 8; i++) send_a(3'd7, 3'd7, 1'b0);
        check("t2_flush_valid", 32'(ia.out_valid), 0);
        check("t2_flush_ready", 32'(ia.in_ready), 0);
        @(negedge clk);
        check("t2_latency_valid", 32'(ia.out_valid), 1);
        expect_a("t2", 392, 8, 0);

        // Early last
        send_a(3'd1, 3'd5, 1'b0);
        send_a(3'd4, 3'd6, 1'b0);
        send_a(3'd3, 3'd3, 1'b1);
        check("t3_flush_ready", 32'(ia.in_ready), 0);
        expect_a("t3", 38, 3, 0);

        // Backpressure: result held for 10 cycles
        send_a(3'd2, 3'd2, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", 32'(ia.out_valid), 1);
            check("t4_hold_sum",   32'(ia.out_sum), 4);
            check("t4_hold_ready", 32'(ia.in_ready), 0);
            @(negedge clk);
        end
        expect_a("t4", 4, 1, 0);
        send_a(3'd1, 3'd3, 1'b1);
        expect_a("t4_next", 3, 1, 0);

        // Bubble inside a burst
        send_a(3'd1, 3'd1, 1'b0);
        repeat (3) @(negedge clk);
        send_a(3'd2, 3'd2, 1'b1);
        expect_a("t4_bubble", 5, 2, 0);

        // in_last on beat BURST_LEN closes exactly one burst
        for (int i = 0; i < 7; i++) send_a(3'd1, 3'd1, 1'b0);
        send_a(3'd1, 3'd1, 1'b1);
        expect_a("t_last8", 8, 8, 0);
        repeat (3) @(negedge clk);
        check("t_last8_no_dup", 32'(ia.out_valid), 0);

        // Overflow on the narrow instance
`ifdef SATURATE_EN
        exp5 = 63;
`else
        exp5 = 34;
`endif
        ib.in_valid = 1'b1; ib.in_a = 3'd7; ib.in_b = 3'd7; ib.in_last = 1'b0;
        check("t5_rdy0", 32'(ib.in_ready), 1);
        @(negedge clk);
        check("t5_rdy1", 32'(ib.in_ready), 1);
        @(negedge clk);
        ib.in_valid = 1'b0;
        check("t5_flush_ready", 32'(ib.in_ready), 0);
        @(negedge clk);
        check("t5_valid", 32'(ib.out_valid), 1);
        check("t5_sum",   32'(ib.out_sum), exp5);
        check("t5_count", 32'(ib.out_count), 2);
        check("t5_ovf",   32'(ib.out_ovf), 1);
        ib.out_ready = 1'b1;
        @(negedge clk);
        ib.out_ready = 1'b0;
        check("t5_pop_valid", 32'(ib.out_valid), 0);

        // Full product table as single-beat bursts with random gaps
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    int n;
                    n = 0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    ic.in_valid = 1'b1;
                    ic.in_a     = 3'(i >> 3);
                    ic.in_b     = 3'(i);
                    ic.in_last  = 1'($urandom_range(0, 1));
                    while (!ic.in_ready && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                    check("t6_in_ready", 32'(ic.in_ready), 1);
                    @(negedge clk);
                    ic.in_valid = 1'b0;
                    ic.in_a     = 3'($urandom_range(0, 7));
                    ic.in_b     = 3'($urandom_range(0, 7));
                end
            end
            begin
                for (int i = 0; i < 64; i++) begin
                    int n;
                    n = 0;
                    while (!ic.out_valid && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    check("t6_valid", 32'(ic.out_valid), 1);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    check("t6_sum",   32'(ic.out_sum), (i >> 3) * (i % 8));
                    check("t6_count", 32'(ic.out_count), 1);
                    ic.out_ready = 1'b1;
                    @(negedge clk);
                    ic.out_ready = 1'b0;
                end
            end
        join
        repeat (5) @(negedge clk);
        check("t6_no_extra", 32'(ic.out_valid), 0);
        check("t6_idle_ready", 32'(ic.in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
